// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: size encodings, FSM states,
// latched request record and lane helpers.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } lsu_state_e;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [1:0]  off;
        logic [31:0] wdata;
    } lsu_req_t;

    // Size 2'b11 behaves exactly like a word access.
    function automatic logic is_word(input logic [1:0] size);
        return size[1];
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        if (is_word(size))
            return off != 2'b00;
        else if (size == SZ_H)
            return off[0];
        else
            return 1'b0;
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational lane logic: little-endian extract/extend for loads and
// read-modify-write merge for sub-word stores.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [1:0]  off,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [BYTE_W-1:0] byte_v;
    logic [HALF_W-1:0] half_v;

    always_comb begin
        byte_v    = rdata[{off, 3'b000} +: BYTE_W];
        half_v    = rdata[{off[1], 4'b0000} +: HALF_W];
        load_data = rdata;
        merged    = wdata;
        case (size)
            SZ_B: begin
                load_data = {{(32-BYTE_W){~uns & byte_v[BYTE_W-1]}}, byte_v};
                merged    = rdata;
                merged[{off, 3'b000} +: BYTE_W] = wdata[BYTE_W-1:0];
            end
            SZ_H: begin
                load_data = {{(32-HALF_W){~uns & half_v[HALF_W-1]}}, half_v};
                merged    = rdata;
                merged[{off[1], 4'b0000} +: HALF_W] = wdata[HALF_W-1:0];
            end
            default: begin
                load_data = rdata;
                merged    = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit driving a word-addressed synchronous RAM port.
// Optional misaligned-access trap: define MISALIGN_TRAP_EN.
//
// Handshakes: a request transfers on the clk edge where req_valid && req_ready;
// a response transfers on the edge where rsp_valid && rsp_ready. A valid, once
// raised, holds its payload stable until that transfer edge.
module mem_lsu
    import lsu_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output lsu_state_e  dbg_state
);

    lsu_state_e  state, next_state;
    lsu_req_t    lat;
    logic        accept;
    logic        misalign;
    logic [31:0] lane_load;
    logic [31:0] lane_merged;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign dbg_state = state;

`ifdef MISALIGN_TRAP_EN
    assign misalign = is_misaligned(req_size, req_addr[1:0]);
`else
    assign misalign = 1'b0;
`endif

    lsu_lane u_lane (
        .size      (lat.size),
        .uns       (lat.uns),
        .off       (lat.off),
        .rdata     (mem_rdata),
        .wdata     (lat.wdata),
        .load_data (lane_load),
        .merged    (lane_merged)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = misalign ? RESP : ISSUE;
            ISSUE:   next_state = (lat.we && is_word(lat.size)) ? RESP : WAIT;
            WAIT:    next_state = lat.we ? WRITE : RESP;
            WRITE:   next_state = RESP;
            RESP:    if (rsp_valid && rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The address is registered on the accept edge so the RAM sees it during
    // ISSUE and its read data is ready to sample in WAIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat       <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            mem_we    <= 1'b0;
            rsp_valid <= (state == RESP) && !(rsp_valid && rsp_ready);
            case (state)
                IDLE: if (accept) begin
                    lat       <= '{we: req_we, size: req_size, uns: req_unsigned,
                                   off: req_addr[1:0], wdata: req_wdata};
                    rsp_rdata <= '0;
                    rsp_err   <= misalign;
                    if (!misalign) begin
                        mem_addr <= (req_addr - BASE_ADDR) >> 2;
                        if (req_we && is_word(req_size)) begin
                            mem_we    <= 1'b1;
                            mem_wdata <= req_wdata;
                        end
                    end
                end
                WAIT: begin
                    if (lat.we) begin
                        mem_we    <= 1'b1;
                        mem_wdata <= lane_merged;
                    end else begin
                        rsp_rdata <= lane_load;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
